ntt_bf_unit: RTL and testbench
==============================

// Module: ntt_bf_unit
// PURPOSE
//   Parametrised, fully pipelined modular butterfly for NTT/INTT datapaths over Z_Q.
//   Supports Cooley-Tukey (forward) and Gentleman-Sande (inverse) modes, selected per beat.
//   Takes a runtime twiddle per beat and has optional divide-by-2 for INTT scaling.
//   Has a valid/enable pipeline. Sits between coefficient memory read ports and the
//   write-back path of an NTT stage; throughput is one butterfly per cycle.
// PARAMETERS
//   W        12    coefficient/twiddle width in bits; Q < 2**W required
//   Q        3329  prime modulus
//   MUL_LAT  3     modular-multiplier pipeline depth (>=1); Barrett constants derived from Q, W
// PORTS
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous, active-low reset
//   en         in   1  pipeline advance; 0 freezes every stage, valid bits included
//   in_valid   in   1  input beat valid (sampled only when en=1)
//   mode       in   1  0 = CT: (u+v*w, u-v*w); 1 = GS: (u+v, (u-v)*w)
//   half       in   1  1 = multiply both results by 2^-1 mod Q (GS/INTT scaling)
//   u, v, w    in   W  operands and twiddle, each < Q
//   out_valid  out  1  output beat valid
//   bf_upper   out  W  upper result, in [0,Q)
//   bf_lower   out  W  lower result, in [0,Q)
// BEHAVIOUR
//   - Latency LAT = MUL_LAT+3 enabled cycles from input sample to output; identical in both modes.
//   - Each beat carries its own mode/half, so back-to-back beats may mix modes.
//   - S0 (input reg): capture u,v,w,mode,half,in_valid when en=1.
//   - Multiplier input: CT feeds (v_r, w_r); GS feeds ((u_r - v_r) mod Q, w_r).
//   - MUL_LAT stages: product = a*b mod Q via 2W-bit product plus Barrett reduction,
//     with final conditional subtract.
//     Side path is delayed by MUL_LAT: CT carries u_r, GS carries (u_r + v_r) mod Q.
//     mode, half and valid are delayed alongside.
//   - S_AS (register):
//       CT: upper = (u + p) mod Q, lower = (u - p) mod Q.
//       GS: upper = delayed sum, lower = p.
//   - S_H (register, drives outputs): when half=1, each x maps to x even ? x>>1 : (x+Q)>>1;
//     when half=0, x passes through.
//   - Mod add: x+y >= Q ? x+y-Q : x+y, computed in W+1 bits.
//     Mod sub: x >= y ? x-y : x-y+Q, computed in W+1 bits.
//   - out_valid is in_valid delayed LAT enabled cycles. Data regs load every enabled cycle;
//     bf_* are don't-care when out_valid=0.
//   - en=0: all registers hold; out_valid and bf_* are unchanged. Beats resume in order
//     when en returns to 1, with none lost or duplicated.
//   - Reset (asynchronous, rst=0): all valid bits = 0, bf_upper = bf_lower = 0,
//     all data regs = 0. Reset mid-operation drops every in-flight beat.
//     out_valid stays 0 until LAT enabled cycles after the first post-reset valid input.
//   - Operands >= Q are illegal. The simulation-only assertion fires on in_valid&en.
//     Outputs for illegal operands are unspecified.
//   - The block has no back-pressure output. The upstream controller owns en.
// TESTING (defaults W=12, Q=3329, MUL_LAT=3, LAT=6)
//   1. CT: u=100, v=1, w=2285, half=0 -> 6 cycles later out_valid=1, upper=2385, lower=1144.
//   2. GS: u=5, v=3, w=2285, half=0 -> upper=8, lower=1241.
//      Same beat with half=1 -> upper=4, lower=2285.
//   3. Wrap: CT u=3328, v=1, w=1 -> upper=0, lower=3327.
//      CT u=0, v=3328, w=3328 -> p=1, upper=1, lower=3328.
//   4. Streaming: 64 consecutive random beats, alternating mode and random half, compared
//      against a reference model -> exact match, exactly 6 cycles each, one result per cycle.
//   5. Stall: hold en=0 for 5 cycles with 3 beats in flight -> outputs frozen;
//      on resume, the 3 results appear in order with no gaps or duplicates.
//   6. Reset: assert rst=0 asynchronously (mid-clock) with 4 beats in flight ->
//      out_valid=0 and bf_*=0 immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/ntt_bf_unit.sv
// Pipelined modular butterfly for NTT/INTT stages over Z_Q, one beat per cycle.
// Per-beat Cooley-Tukey / Gentleman-Sande selection and optional halving.
module ntt_bf_unit #(
  parameter int W       = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic         mode,
  input  logic         half,
  input  logic [W-1:0] u,
  input  logic [W-1:0] v,
  input  logic [W-1:0] w,
  output logic         out_valid,
  output logic [W-1:0] bf_upper,
  output logic [W-1:0] bf_lower
);

  // Handshake: a beat is accepted when en && in_valid at a rising clk edge;
  // out_valid marks a result LAT enabled cycles later; en=0 freezes everything.

  localparam int K = 2 * W;
  localparam logic [W:0]   QW = (W + 1)'(Q);
  localparam logic [K-1:0] QK = K'(Q);
  // floor(2^K / Q); with products below 2^K the quotient estimate is short by at most 1
  localparam logic [K-1:0] BM = K'((64'd1 << K) / 64'(Q));

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QW) s = s - QW;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + QW - {1'b0, y};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + QW) : {1'b0, x};
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] barrett_quot(input logic [K-1:0] x);
    logic [2*K-1:0] t;
    t = {{K{1'b0}}, x} * {{K{1'b0}}, BM};
    return t[K+W-1:K];
  endfunction

  function automatic logic [W-1:0] barrett_fix(input logic [K-1:0] x, input logic [W-1:0] qe);
    logic [K-1:0] r;
    r = x - ({{(K-W){1'b0}}, qe} * QK);
    if (r >= QK) r = r - QK;
    return r[W-1:0];
  endfunction

  // Input register stage
  logic [W-1:0] u_q, v_q, w_q;
  logic         mode_q, half_q, vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q    <= '0;
      v_q    <= '0;
      w_q    <= '0;
      mode_q <= 1'b0;
      half_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (en) begin
      u_q    <= u;
      v_q    <= v;
      w_q    <= w;
      mode_q <= mode;
      half_q <= half;
      vld_q  <= in_valid;
    end
  end

  logic [W-1:0] mul_a_d, side_d, mul_p;
  logic [K-1:0] prod_d;

  always_comb begin
    mul_a_d = v_q;
    side_d  = u_q;
    if (mode_q) begin
      mul_a_d = mod_sub(u_q, v_q);
      side_d  = mod_add(u_q, v_q);
    end
    prod_d = {{W{1'b0}}, mul_a_d} * {{W{1'b0}}, w_q};
  end

  // Side path and per-beat control, delayed to line up with the multiplier
  logic [W-1:0]       side_q [MUL_LAT];
  logic [MUL_LAT-1:0] md_q, hf_q, vl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) side_q[i] <= '0;
      md_q <= '0;
      hf_q <= '0;
      vl_q <= '0;
    end else if (en) begin
      side_q[0] <= side_d;
      md_q[0]   <= mode_q;
      hf_q[0]   <= half_q;
      vl_q[0]   <= vld_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        side_q[i] <= side_q[i-1];
        md_q[i]   <= md_q[i-1];
        hf_q[i]   <= hf_q[i-1];
        vl_q[i]   <= vl_q[i-1];
      end
    end
  end

  // Modular multiplier: product, Barrett quotient, correction, then plain delay
  generate
    if (MUL_LAT == 1) begin : g_lat1
      logic [W-1:0] p_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    p_q <= '0;
        else if (en) p_q <= barrett_fix(prod_d, barrett_quot(prod_d));
      end
      assign mul_p = p_q;
    end else begin : g_latn
      logic [K-1:0] prod_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    prod_q <= '0;
        else if (en) prod_q <= prod_d;
      end
      if (MUL_LAT == 2) begin : g_lat2
        logic [W-1:0] p_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)    p_q <= '0;
          else if (en) p_q <= barrett_fix(prod_q, barrett_quot(prod_q));
        end
        assign mul_p = p_q;
      end else begin : g_lat3p
        logic [K-1:0] x_q;
        logic [W-1:0] qe_q;
        logic [W-1:0] p_q [MUL_LAT-2];
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            x_q  <= '0;
            qe_q <= '0;
            for (int i = 0; i < MUL_LAT - 2; i++) p_q[i] <= '0;
          end else if (en) begin
            x_q    <= prod_q;
            qe_q   <= barrett_quot(prod_q);
            p_q[0] <= barrett_fix(x_q, qe_q);
            for (int i = 1; i < MUL_LAT - 2; i++) p_q[i] <= p_q[i-1];
          end
        end
        assign mul_p = p_q[MUL_LAT-3];
      end
    end
  endgenerate

  // Add/sub stage
  logic [W-1:0] as_up_d, as_lo_d, as_up_q, as_lo_q;
  logic         as_half_q, as_vld_q;

  always_comb begin
    as_up_d = side_q[MUL_LAT-1];
    as_lo_d = mul_p;
    if (!md_q[MUL_LAT-1]) begin
      as_up_d = mod_add(side_q[MUL_LAT-1], mul_p);
      as_lo_d = mod_sub(side_q[MUL_LAT-1], mul_p);
    end
  end

  logic [W-1:0] up_d, lo_d, up_q, lo_q;
  logic         out_vld_q;

  always_comb begin
    up_d = as_half_q ? halve(as_up_q) : as_up_q;
    lo_d = as_half_q ? halve(as_lo_q) : as_lo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_up_q   <= '0;
      as_lo_q   <= '0;
      as_half_q <= 1'b0;
      as_vld_q  <= 1'b0;
      up_q      <= '0;
      lo_q      <= '0;
      out_vld_q <= 1'b0;
    end else if (en) begin
      as_up_q   <= as_up_d;
      as_lo_q   <= as_lo_d;
      as_half_q <= hf_q[MUL_LAT-1];
      as_vld_q  <= vl_q[MUL_LAT-1];
      up_q      <= up_d;
      lo_q      <= lo_d;
      out_vld_q <= as_vld_q;
    end
  end

  assign out_valid = out_vld_q;
  assign bf_upper  = up_q;
  assign bf_lower  = lo_q;

  a_operands_in_range: assert property (@(posedge clk) disable iff (!rst)
    (en && in_valid) |-> ({1'b0, u} < QW && {1'b0, v} < QW && {1'b0, w} < QW));

endmodule

// File: tb/tb_ntt_bf_unit.sv
// Directed bench for ntt_bf_unit: known vectors, streaming, stall and async reset.
module tb_ntt_bf_unit;
  localparam int W   = 12;
  localparam int Q   = 3329;
  localparam int LAT = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         en, in_valid, mode, half;
  logic [W-1:0] u, v, w;
  logic         out_valid;
  logic [W-1:0] bf_upper, bf_lower;

  ntt_bf_unit #(.W(W), .Q(Q), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode), .half(half),
    .u(u), .v(v), .w(w),
    .out_valid(out_valid), .bf_upper(bf_upper), .bf_lower(bf_lower)
  );

  // scoreboard
  logic [W-1:0] exp_up_q[$];
  logic [W-1:0] exp_lo_q[$];
  int           due_q[$];
  int           ecyc = 0;
  logic         last_v = 1'b0;
  logic [W-1:0] last_up = '0, last_lo = '0;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (enabled cycle %0d)", tag, obs, exp, ecyc);
    end
  endtask

  function automatic int m_half(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  task automatic model(input int uu, input int vv, input int ww, input bit md, input bit hf,
                       output int eu, output int el);
    int p;
    if (!md) begin
      p  = (vv * ww) % Q;
      eu = (uu + p) % Q;
      el = (uu - p + Q) % Q;
    end else begin
      eu = (uu + vv) % Q;
      el = (((uu - vv + Q) % Q) * ww) % Q;
    end
    if (hf) begin
      eu = m_half(eu);
      el = m_half(el);
    end
  endtask

  // driver: apply one cycle of inputs, then check outputs #1 after the edge
  task automatic step(input bit e, input bit vld, input bit md, input bit hf,
                      input int uu, input int vv, input int ww, input int eu, input int el);
    en = e; in_valid = vld; mode = md; half = hf;
    u = W'(uu); v = W'(vv); w = W'(ww);
    @(posedge clk);
    if (e) begin
      ecyc++;
      if (vld) begin
        exp_up_q.push_back(W'(eu));
        exp_lo_q.push_back(W'(el));
        due_q.push_back(ecyc + LAT - 1);
      end
      last_v = 1'b0;
      if (due_q.size() > 0 && due_q[0] == ecyc) begin
        last_v  = 1'b1;
        last_up = exp_up_q.pop_front();
        last_lo = exp_lo_q.pop_front();
        void'(due_q.pop_front());
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(last_v));
    if (last_v) begin
      check("bf_upper", 32'(bf_upper), 32'(last_up));
      check("bf_lower", 32'(bf_lower), 32'(last_lo));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_beat(input bit e, input bit md);
    int uu, vv, ww, eu, el;
    bit hf;
    uu = $urandom_range(0, Q - 1);
    vv = $urandom_range(0, Q - 1);
    ww = $urandom_range(0, Q - 1);
    hf = 1'($urandom_range(0, 1));
    model(uu, vv, ww, md, hf, eu, el);
    step(e, 1'b1, md, hf, uu, vv, ww, eu, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; mode = 1'b0; half = 1'b0;
    u = '0; v = '0; w = '0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_bf_upper", 32'(bf_upper), 32'd0);
    check("reset_bf_lower", 32'(bf_lower), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // CT basic, exact latency
    step(1'b1, 1'b1, 1'b0, 1'b0, 100, 1, 2285, 2385, 1144);
    idle(LAT);

    // GS without and with halving, then CT wrap cases, back to back
    step(1'b1, 1'b1, 1'b1, 1'b0, 5, 3, 2285, 8, 1241);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5, 3, 2285, 4, 2285);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3328, 1, 1, 0, 3327);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 3328, 3328, 1, 3328);
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    idle(LAT);

    // streaming: 64 beats, alternating mode, random half
    for (int i = 0; i < 64; i++) rand_beat(1'b1, 1'(i % 2));
    idle(LAT);

    // stall with 3 beats in flight; in_valid held high while en=0
    rand_beat(1'b1, 1'b0);
    rand_beat(1'b1, 1'b1);
    rand_beat(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rand_beat(1'b0, 1'b1);
    idle(LAT);

    // stall with a result sitting on the outputs
    rand_beat(1'b1, 1'b1);
    rand_beat(1'b1, 1'b0);
    idle(LAT - 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    idle(LAT);

    // asynchronous reset mid-clock with 4 beats in flight
    for (int i = 0; i < 4; i++) rand_beat(1'b1, 1'(i % 2));
    #3;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_bf_upper", 32'(bf_upper), 32'd0);
    check("midreset_bf_lower", 32'(bf_lower), 32'd0);
    exp_up_q.delete();
    exp_lo_q.delete();
    due_q.delete();
    last_v = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle(LAT + 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100, 1, 2285, 2385, 1144);
    idle(LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
